uart_crossrx_ctrl: RTL

//  Frame-buffer controller for the UART cross-RX path; owns the 2048x8 simple dual-port RAM (both ports on clk).

---
 rtl/uart_crossrx_pkg.sv | 9 +
 rtl/uart_crossrx_sfifo.sv | 49 ++++
 rtl/uart_crossrx_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_crossrx_pkg.sv
// rtl/uart_crossrx_pkg.sv - shared constants and read FSM states for the UART cross-RX frame buffer
package uart_crossrx_pkg;
  localparam int ADDR_W    = 11;
  localparam int LEN_W     = ADDR_W + 1;
  localparam int RD_LAT    = 2;
  localparam int OFIFO_DEP = 4;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} rd_state_t;
endpackage

// File: rtl/uart_crossrx_sfifo.sv
// rtl/uart_crossrx_sfifo.sv - generic single-clock FIFO with combinational head, DEP a power of 2
module uart_crossrx_sfifo #(
  parameter int W   = 8,
  parameter int DEP = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEP):0]   count
);
  localparam int AW = $clog2(DEP);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEP];
  logic [AW-1:0] wp, rp;
  logic          wr_en, rd_en;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEP));
  assign head  = mem[rp];
  // A pop frees the slot the same cycle, so push is honoured even when full.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wp] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_en) wp <= wp + AW'(1);
      if (rd_en) rp <= rp + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_crossrx_ctrl.sv
// rtl/uart_crossrx_ctrl.sv - UART cross-RX frame buffer controller; UART_CROSSRX_STAT_EN adds frame/drop counters
module uart_crossrx_ctrl #(
  parameter int ADDR_W   = uart_crossrx_pkg::ADDR_W,
  parameter int RD_LAT   = uart_crossrx_pkg::RD_LAT,
  parameter int IDLE_CYC = 1000,
  parameter int MAX_FRM  = 1024,
  parameter int DESC_DEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_vld,
  input  logic [7:0]        rx_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [7:0]        ram_data,
  output logic [ADDR_W-1:0] ram_rdaddr,
  input  logic [7:0]        ram_q,
  output logic              m_vld,
  output logic [7:0]        m_data,
  output logic              m_last,
  input  logic              m_rdy,
  output logic              frm_pend,
  output logic              drop_pulse
`ifdef UART_CROSSRX_STAT_EN
  ,
  output logic [15:0]       stat_frm,
  output logic [15:0]       stat_drop
`endif
);
  import uart_crossrx_pkg::*;

  localparam int LW  = ADDR_W + 1;
  localparam int IW  = $clog2(IDLE_CYC + 1);
  localparam int DCW = $clog2(DESC_DEP) + 1;
  localparam int OCW = $clog2(OFIFO_DEP) + 1;

  logic [LW-1:0] wr_ptr, frm_base, rd_base, rd_ptr, cur_len, rd_left, rd_len, used, desc_len, desc_head;
  logic [IW-1:0] idle_cnt;
  logic          bad, full, frame_start, refuse, accept, max_close, idle_close, good_close, bad_close;
  logic          desc_pop, desc_empty, desc_full;
  logic [DCW-1:0] desc_count;

  assign used        = wr_ptr - rd_base;
  assign full        = (used == (LW'(1) << ADDR_W));
  assign frame_start = (cur_len == '0) && !bad;
  assign refuse      = full || (frame_start && desc_full);
  assign accept      = rx_vld && !bad && !refuse;
  assign max_close   = accept && (cur_len + LW'(1) == LW'(MAX_FRM));
  assign idle_close  = !rx_vld && (idle_cnt == IW'(IDLE_CYC - 1)) && (cur_len != '0 || bad);
  assign good_close  = max_close || (idle_close && !bad);
  assign bad_close   = idle_close && bad;
  assign desc_len    = max_close ? LW'(MAX_FRM) : cur_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wren   <= 1'b0;
      ram_wraddr <= '0;
      ram_data   <= '0;
      drop_pulse <= 1'b0;
      idle_cnt   <= '0;
      bad        <= 1'b0;
      wr_ptr     <= '0;
      frm_base   <= '0;
      cur_len    <= '0;
    end else begin
      ram_wren   <= accept;
      drop_pulse <= bad_close;
      if (accept) begin
        ram_wraddr <= wr_ptr[ADDR_W-1:0];
        ram_data   <= rx_data;
      end
      if (rx_vld) idle_cnt <= '0;
      else if (idle_cnt != IW'(IDLE_CYC - 1)) idle_cnt <= idle_cnt + IW'(1);
      if (rx_vld && !bad && refuse) bad <= 1'b1;
      else if (bad_close) bad <= 1'b0;
      // A bad frame is discarded by rewinding to where it began.
      if (bad_close) wr_ptr <= frm_base;
      else if (accept) wr_ptr <= wr_ptr + LW'(1);
      if (good_close) begin
        frm_base <= accept ? wr_ptr + LW'(1) : wr_ptr;
        cur_len  <= '0;
      end else if (bad_close) begin
        cur_len  <= '0;
      end else if (accept) begin
        cur_len  <= cur_len + LW'(1);
      end
    end
  end

  uart_crossrx_sfifo #(.W(LW), .DEP(DESC_DEP)) u_desc (
    .clk(clk), .rst_n(rst_n), .push(good_close), .push_data(desc_len), .pop(desc_pop),
    .head(desc_head), .empty(desc_empty), .full(desc_full), .count(desc_count)
  );

  rd_state_t       state, state_nx;
  logic [RD_LAT-1:0] pipe_vld, pipe_last;
  logic [8:0]      ofifo_head;
  logic            ofifo_empty, ofifo_full, ofifo_pop, last_acc, issue;
  logic [OCW-1:0]  ofifo_count;
  logic [7:0]      occ;

  assign m_vld      = !ofifo_empty;
  assign m_data     = m_vld ? ofifo_head[7:0] : 8'h00;
  assign m_last     = m_vld && ofifo_head[8];
  assign ofifo_pop  = m_vld && m_rdy;
  assign last_acc   = ofifo_pop && ofifo_head[8];
  assign ram_rdaddr = rd_ptr[ADDR_W-1:0];
  assign frm_pend   = !desc_empty || (state != IDLE);

  // Reads still in the RAM pipeline already own an output FIFO slot.
  always_comb begin
    occ = 8'(ofifo_count);
    for (int i = 0; i < RD_LAT; i++) occ = occ + 8'(pipe_vld[i]);
  end

  always_comb begin
    state_nx = state;
    desc_pop = 1'b0;
    issue    = 1'b0;
    case (state)
      IDLE:  if (!desc_empty) state_nx = LOAD;
      LOAD:  begin
        desc_pop = 1'b1;
        state_nx = RUN;
      end
      RUN:   if (occ < 8'(OFIFO_DEP)) begin
        issue = 1'b1;
        if (rd_left == LW'(1)) state_nx = DRAIN;
      end
      DRAIN: if (last_acc) state_nx = desc_empty ? IDLE : LOAD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      rd_left   <= '0;
      rd_len    <= '0;
      rd_base   <= '0;
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      state <= state_nx;
      if (state == LOAD) begin
        rd_left <= desc_head;
        rd_len  <= desc_head;
      end else if (issue) begin
        rd_left <= rd_left - LW'(1);
      end
      if (issue) rd_ptr <= rd_ptr + LW'(1);
      pipe_vld  <= (pipe_vld << 1) | RD_LAT'(issue);
      pipe_last <= (pipe_last << 1) | RD_LAT'(issue && rd_left == LW'(1));
      // Space is returned only once the consumer has taken the whole frame.
      if (last_acc) rd_base <= rd_base + rd_len;
    end
  end

  uart_crossrx_sfifo #(.W(9), .DEP(OFIFO_DEP)) u_ofifo (
    .clk(clk), .rst_n(rst_n), .push(pipe_vld[RD_LAT-1]), .push_data({pipe_last[RD_LAT-1], ram_q}),
    .pop(ofifo_pop), .head(ofifo_head), .empty(ofifo_empty), .full(ofifo_full), .count(ofifo_count)
  );

  logic unused_sink;
  assign unused_sink = ^{desc_count, ofifo_full};

`ifdef UART_CROSSRX_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frm  <= '0;
      stat_drop <= '0;
    end else begin
      if (good_close && stat_frm != 16'hFFFF) stat_frm <= stat_frm + 16'd1;
      if (bad_close && stat_drop != 16'hFFFF) stat_drop <= stat_drop + 16'd1;
    end
  end
`endif
endmodule
